// File: rtl/scanline_sequencer.sv
// -----------------------------------------------------------------------------
// scanline_sequencer
//   Top-level controller for the increment-term calculator (L_kn = 2k+1+B_n).
//   It walks one full sector scan. For each scanline it loads R_0 and the line
//   angle, pulses configure, and then steps through every scan point. Each
//   point's term vector goes to the downstream consumer over a valid/ready
//   handshake. The calculator ack, and final_scanpoint with it, is issued only
//   after the consumer has taken the point.
//
// Optional feature (macro SEQ_WATCHDOG_EN):
//   Adds a WAIT_RDY watchdog. If calc_ready does not arrive within WDOG_CYCLES
//   cycles, the block pulses calc_rst, sets a sticky error flag and aborts the
//   scan without a done pulse. With the macro undefined, calc_rst and error are
//   tied to 0 and WAIT_RDY waits indefinitely.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 one-cycle request to begin a sector scan
//   r0_cfg                R_0 applied to every line
//   angle_start           angle of line 0
//   angle_step            angle increment per line (wraps modulo 2^DW_ANGLE)
//   num_points            points per line
//   num_lines             lines per sector
//   calc_configure        configure pulse to calculator
//   calc_ack              ack pulse to calculator
//   calc_final_scanpoint  last-point flag, valid with calc_ack
//   calc_r_0, calc_angle  line parameters to calculator
//   calc_rst              calculator reset (watchdog abort only)
//   calc_ready            calculator result ready
//   point_valid           term vector valid to consumer
//   point_ready           consumer accepts
//   point_idx, line_idx   current point k and current line
//   busy                  scan in progress
//   done                  one-cycle pulse when the sector is complete
//   error                 sticky watchdog flag
// -----------------------------------------------------------------------------
module scanline_sequencer #(
  parameter int unsigned DW_INPUT  = 8,
  parameter int unsigned DW_ANGLE  = 8,
  parameter int unsigned DW_POINTS = 10,
  parameter int unsigned DW_LINES  = 8
`ifdef SEQ_WATCHDOG_EN
  ,
  parameter int unsigned WDOG_CYCLES = 1024
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DW_INPUT-1:0]  r0_cfg,
  input  logic [DW_ANGLE-1:0]  angle_start,
  input  logic [DW_ANGLE-1:0]  angle_step,
  input  logic [DW_POINTS-1:0] num_points,
  input  logic [DW_LINES-1:0]  num_lines,
  output logic                 calc_configure,
  output logic                 calc_ack,
  output logic                 calc_final_scanpoint,
  output logic [DW_INPUT-1:0]  calc_r_0,
  output logic [DW_ANGLE-1:0]  calc_angle,
  output logic                 calc_rst,
  input  logic                 calc_ready,
  output logic                 point_valid,
  input  logic                 point_ready,
  output logic [DW_POINTS-1:0] point_idx,
  output logic [DW_LINES-1:0]  line_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CONFIG    = 3'd1,
    S_WAIT_RDY  = 3'd2,
    S_PRESENT   = 3'd3,
    S_ACK       = 3'd4,
    S_NEXT_LINE = 3'd5,
    S_FINISH    = 3'd6
  } state_t;

  state_t               state;
  logic [DW_ANGLE-1:0]  step_q;
  logic [DW_POINTS-1:0] num_points_q;
  logic [DW_LINES-1:0]  num_lines_q;

  logic start_ok_c;
  logic last_point_c;
  logic last_line_c;
  logic wdog_expire_c;

  // A scan is accepted only from IDLE with both counts non-zero.
  assign start_ok_c   = (state == S_IDLE) && start &&
                        (num_points != '0) && (num_lines != '0);
  assign last_point_c = (point_idx == (num_points_q - DW_POINTS'(1)));
  assign last_line_c  = (line_idx  == (num_lines_q  - DW_LINES'(1)));

`ifdef SEQ_WATCHDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_cnt;

  // Fires on the WDOG_CYCLES-th consecutive WAIT_RDY cycle without calc_ready.
  assign wdog_expire_c = (state == S_WAIT_RDY) && !calc_ready &&
                         (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));

  // Watchdog counter, calculator reset pulse and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt <= '0;
      calc_rst <= 1'b0;
      error    <= 1'b0;
    end else begin
      calc_rst <= wdog_expire_c;
      if (state == S_WAIT_RDY && !calc_ready && !wdog_expire_c) begin
        wdog_cnt <= wdog_cnt + WDOG_W'(1);
      end else begin
        wdog_cnt <= '0;
      end
      if (wdog_expire_c) begin
        error <= 1'b1;
      end else if (start_ok_c) begin
        error <= 1'b0;
      end
    end
  end
`else
  assign wdog_expire_c = 1'b0;
  assign calc_rst      = 1'b0;
  assign error         = 1'b0;
`endif

  // Main sequencer FSM. All outputs are registered. Pulse outputs default low
  // each cycle and are raised on entry into the state that owns them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= S_IDLE;
      step_q               <= '0;
      num_points_q         <= '0;
      num_lines_q          <= '0;
      calc_configure       <= 1'b0;
      calc_ack             <= 1'b0;
      calc_final_scanpoint <= 1'b0;
      calc_r_0             <= '0;
      calc_angle           <= '0;
      point_valid          <= 1'b0;
      point_idx            <= '0;
      line_idx             <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
    end else begin
      calc_configure       <= 1'b0;
      calc_ack             <= 1'b0;
      calc_final_scanpoint <= 1'b0;
      done                 <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start_ok_c) begin
            step_q         <= angle_step;
            num_points_q   <= num_points;
            num_lines_q    <= num_lines;
            calc_r_0       <= r0_cfg;
            calc_angle     <= angle_start;
            point_idx      <= '0;
            line_idx       <= '0;
            busy           <= 1'b1;
            calc_configure <= 1'b1;
            state          <= S_CONFIG;
          end else if (start) begin
            // Empty sector: report completion without touching the calculator.
            done <= 1'b1;
          end
        end

        S_CONFIG: begin
          state <= S_WAIT_RDY;
        end

        S_WAIT_RDY: begin
          if (calc_ready) begin
            point_valid <= 1'b1;
            state       <= S_PRESENT;
          end else if (wdog_expire_c) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end

        S_PRESENT: begin
          if (point_ready) begin
            point_valid          <= 1'b0;
            calc_ack             <= 1'b1;
            calc_final_scanpoint <= last_point_c;
            state                <= S_ACK;
          end
        end

        S_ACK: begin
          if (!last_point_c) begin
            point_idx <= point_idx + DW_POINTS'(1);
            state     <= S_WAIT_RDY;
          end else if (last_line_c) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_FINISH;
          end else begin
            point_idx  <= '0;
            line_idx   <= line_idx + DW_LINES'(1);
            calc_angle <= calc_angle + step_q;
            state      <= S_NEXT_LINE;
          end
        end

        // One quiet cycle lets the calculator settle back to idle.
        S_NEXT_LINE: begin
          calc_configure <= 1'b1;
          state          <= S_CONFIG;
        end

        S_FINISH: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/scanline_sequencer.md
Name: scanline_sequencer

Overview:
- Top-level controller for the increment-term calculator (the L_kn = 2k+1+B_n block).
- Walks a full sector scan: for each scanline it sets R_0 and angle, pulses configure, then steps through every scan point.
- Each point's term vector is handed to a downstream consumer (comparator/delay bank) with a valid/ready handshake. Calculator ack and final_scanpoint are issued only after the consumer accepts.

Parameters:
DW_INPUT, 8, width of R_0 start value
DW_ANGLE, 8, width of angle and angle step
DW_POINTS, 10, width of point counter / num_points
DW_LINES, 8, width of line counter / num_lines
WDOG_CYCLES, 1024, watchdog limit (only with SEQ_WATCHDOG_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a sector scan
r0_cfg  in  DW_INPUT  R_0 applied to every line
angle_start  in  DW_ANGLE  angle of line 0
angle_step  in  DW_ANGLE  angle increment per line
num_points  in  DW_POINTS  points per line
num_lines  in  DW_LINES  lines per sector
calc_configure  out  1  configure pulse to calculator
calc_ack  out  1  ack pulse to calculator
calc_final_scanpoint  out  1  final-point flag, valid with calc_ack
calc_r_0  out  DW_INPUT  R_0 to calculator
calc_angle  out  DW_ANGLE  angle to calculator
calc_rst  out  1  calculator reset (watchdog only; tied 0 otherwise)
calc_ready  in  1  calculator result ready
point_valid  out  1  term vector valid to consumer
point_ready  in  1  consumer accepts
point_idx  out  DW_POINTS  current point k
line_idx  out  DW_LINES  current line
busy  out  1  scan in progress
done  out  1  one-cycle pulse, sector complete
error  out  1  sticky watchdog flag (0 without macro)

Behaviour:
- Reset: every output is 0. FSM is in IDLE; counters and latched config are 0.
- States: IDLE, CONFIG, WAIT_RDY, PRESENT, ACK, NEXT_LINE, FINISH.
- IDLE:
  - start with num_points!=0 and num_lines!=0: latch r0_cfg, angle_start, angle_step, num_points, num_lines; go to CONFIG; busy=1.
  - start with either count 0: pulse done the next cycle; no calculator activity.
  - start while busy: ignored.
- CONFIG:
  - calc_configure=1 for exactly one cycle, then go to WAIT_RDY.
  - calc_r_0 and calc_angle are registered and held stable from CONFIG until the line's final ack.
- WAIT_RDY: on calc_ready=1, go to PRESENT.
- PRESENT:
  - point_valid=1, held until point_ready is sampled high.
  - point_idx and line_idx are stable while valid.
  - On point_ready: go to ACK.
- ACK:
  - calc_ack=1 for one cycle.
  - calc_final_scanpoint = (point_idx == num_points-1) in the same cycle.
  - Not final: point_idx+1, go to WAIT_RDY.
  - Final with line_idx == num_lines-1: go to FINISH.
  - Final otherwise: point_idx=0, line_idx+1, calc_angle = calc_angle + angle_step (mod 2^DW_ANGLE, no clamp), go to NEXT_LINE.
- NEXT_LINE: one idle cycle so the calculator returns to its idle state, then CONFIG.
- FINISH: done=1 for one cycle, busy=0, go to IDLE.
- Latency from ack to next calc_ready is set by the calculator; the sequencer adds no cycles beyond the states above.
- point_valid never rises in the same cycle as calc_ack.
- rst mid-scan: immediate return to IDLE, all outputs 0, no done pulse.

Optional Feature:
- SEQ_WATCHDOG_EN defined:
  - Counter runs in WAIT_RDY.
  - If it reaches WDOG_CYCLES without calc_ready: calc_rst=1 for one cycle, error sets (sticky until rst or next accepted start), FSM goes to IDLE without a done pulse.
- Undefined: no counter; calc_rst and error tied 0; WAIT_RDY waits indefinitely.

Test Plan:
- num_lines=2, num_points=3, angle_start=60, angle_step=30, r0_cfg=20, point_ready=1 -> 2 configure pulses; calc_angle 60 then 90; 6 valid/ack pairs; final_scanpoint only on acks 3 and 6; calc_r_0=20 throughout; done pulses once.
- Consumer backpressure: point_ready low 5 cycles at point 1 -> point_valid, point_idx=1 held; no calc_ack until ready.
- num_points=0 with start -> done pulses one cycle later; calc_configure never asserts.
- Wrap: angle_start=250, angle_step=10, num_lines=2 -> second line calc_angle=4.
- rst asserted during PRESENT of line 1 point 2 -> all outputs 0 next cycle; new start runs a full scan correctly.
- SEQ_WATCHDOG_EN with WDOG_CYCLES=16 and calc_ready held 0 -> calc_rst pulse at cycle 16 of WAIT_RDY; error=1; busy=0; no done.
